// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and memory-wait freeze,
// with saturating stall/flush statistics and a sticky data-memory timeout error.
module hazard_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic [4:0]       rd_ex,
  input  logic             MemRead_ex,
  input  logic             branch_taken_ex,
  input  logic             dmem_req_mem,
  input  logic             dmem_ready,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEX_bubble,
  output logic             pc_sel_branch,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             pipe_en,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StErr     = 2'd2
  } state_e;

  localparam logic [TO_W-1:0]  TimeoutVal = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0]  WaitOne    = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntOne     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};

  state_e           r_state;
  state_e           w_state_d;
  logic [TO_W-1:0]  r_wait_cnt;
  logic [TO_W-1:0]  w_wait_cnt_d;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             r_mem_err;

  logic w_mem_stall;
  logic w_freeze;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_lu_haz;
  logic w_stall_inc;
  logic w_flush_inc;

  always_comb begin
    w_mem_stall = dmem_req_mem && !dmem_ready;
    w_freeze    = w_mem_stall || (r_state == StErr);
    w_rs1_hit   = use_rs1_id && (rs1_id == rd_ex);
    w_rs2_hit   = use_rs2_id && (rs2_id == rd_ex);
    w_lu_haz    = MemRead_ex && (rd_ex != 5'd0) && (w_rs1_hit || w_rs2_hit);
  end

  // Priority: freeze > taken branch (squashes the hazarding ID instr) > load-use > normal.
  always_comb begin
    PCWrite       = 1'b0;
    IFIDWrite     = 1'b0;
    IDEX_bubble   = 1'b0;
    pc_sel_branch = 1'b0;
    IFID_flush    = 1'b0;
    IDEX_flush    = 1'b0;
    pipe_en       = 1'b0;
    if (!reset && !w_freeze) begin
      if (branch_taken_ex) begin
        pc_sel_branch = 1'b1;
        IFID_flush    = 1'b1;
        IDEX_flush    = 1'b1;
        PCWrite       = 1'b1;
        IFIDWrite     = 1'b1;
        pipe_en       = 1'b1;
      end else if (w_lu_haz) begin
        IDEX_bubble = 1'b1;
        pipe_en     = 1'b1;
      end else begin
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        pipe_en   = 1'b1;
      end
    end
  end

  always_comb begin
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    if (w_freeze) begin
      w_stall_inc = (r_state != StErr);
    end else if (branch_taken_ex) begin
      w_flush_inc = 1'b1;
    end else if (w_lu_haz) begin
      w_stall_inc = 1'b1;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_wait_cnt_d = r_wait_cnt;
    case (r_state)
      StRun: begin
        if (w_mem_stall) begin
          w_state_d    = StMemWait;
          w_wait_cnt_d = WaitOne;
        end
      end
      StMemWait: begin
        if (dmem_ready) begin
          w_state_d    = StRun;
          w_wait_cnt_d = '0;
        end else if (r_wait_cnt == TimeoutVal) begin
          w_state_d = StErr;
        end else begin
          w_wait_cnt_d = r_wait_cnt + WaitOne;
        end
      end
      StErr: begin
        w_state_d = StErr;
      end
      default: begin
        w_state_d    = StRun;
        w_wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StRun;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_wait_cnt <= w_wait_cnt_d;
      r_mem_err  <= r_mem_err || (w_state_d == StErr);
      if (w_stall_inc && (r_stall_cnt != CntMax)) begin
        r_stall_cnt <= r_stall_cnt + CntOne;
      end
      if (w_flush_inc && (r_flush_cnt != CntMax)) begin
        r_flush_cnt <= r_flush_cnt + CntOne;
      end
    end
  end

  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
